// File: rtl/vs_seq_pkg.sv
// Shared constants and helpers for the input-conditioning (sync + debounce) blocks.
package vs_seq_pkg;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int DEBOUNCE_CYCLES_MIN = 1;

  // Counter width able to hold 0..n.
  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vs_sync_chain.sv
// Multi-flop synchroniser; q is the last stage of an async-reset shift chain.
module vs_sync_chain import vs_seq_pkg::*; #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sr <= {SYNC_STAGES{RESET_VALUE}};
    else          sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/vs_debounce_sync.sv
// Synchronise a bouncing async input, debounce it with a counter, and emit a
// clean level plus single-cycle rise/fall pulses.
module vs_debounce_sync import vs_seq_pkg::*; #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  input  logic sample_en,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("vs_debounce_sync: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_deb
    $error("vs_debounce_sync: DEBOUNCE_CYCLES must be >= %0d", DEBOUNCE_CYCLES_MIN);
  end

  logic          sync_out;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, rise_nxt, fall_nxt;

  vs_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (async_in),
    .q       (sync_out)
  );

  // cnt==0 is STABLE, anything else is QUALIFY; a match at any time drops
  // back to STABLE so short excursions never reach the terminal count.
  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sync_out == level_out) begin
      cnt_nxt = '0;
    end else if (!sample_en) begin
      cnt_nxt = cnt;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      level_nxt = sync_out;
      rise_nxt  = sync_out;
      fall_nxt  = ~sync_out;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      level_out  <= RESET_VALUE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= (cnt_nxt != '0);
    end
  end

endmodule
